seletor_modo: RTL

- Mode controller for the digital clock display path.
- Turns the raw MODE push-button into the one-hot mode selects (modo_relogio … modo_ajuste_timer) that drive the digit selector.
- Sequences the five modes, returns from adjustment modes on inactivity, and forces TIMER mode on a timer alarm.
- Sits between board I/O plus the 1 Hz divider and the display digit selector / per-mode counters.

---
 rtl/seletor_modo_pkg.sv | 47 ++++
 rtl/seletor_modo_debounce_botao.sv | 53 +++++
 rtl/seletor_modo.sv | 116 +++++++++++
 3 files changed

// File: rtl/seletor_modo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seletor_modo_pkg
// Description : Mode enumeration, sequence helpers and timeout width for the
//               display mode controller.
// Revision    : 1.0 - initial release
// ============================================================================
package seletor_modo_pkg;

    localparam int c_TIMEOUT_W = 5;

    typedef enum logic [2:0] {
        RELOGIO        = 3'd0,
        CRONOMETRO     = 3'd1,
        TIMER          = 3'd2,
        AJUSTE_RELOGIO = 3'd3,
        AJUSTE_TIMER   = 3'd4
    } modo_t;

    function automatic modo_t proximo_modo(input modo_t m);
        case (m)
            RELOGIO:        proximo_modo = CRONOMETRO;
            CRONOMETRO:     proximo_modo = TIMER;
            TIMER:          proximo_modo = AJUSTE_RELOGIO;
            AJUSTE_RELOGIO: proximo_modo = AJUSTE_TIMER;
            default:        proximo_modo = RELOGIO;
        endcase
    endfunction

    function automatic logic is_ajuste(input modo_t m);
        is_ajuste = (m == AJUSTE_RELOGIO) || (m == AJUSTE_TIMER);
    endfunction

    // Bit order: {ajuste_timer, ajuste_relogio, timer, cronometro, relogio}
    function automatic logic [4:0] decodifica(input modo_t m);
        case (m)
            RELOGIO:        decodifica = 5'b00001;
            CRONOMETRO:     decodifica = 5'b00010;
            TIMER:          decodifica = 5'b00100;
            AJUSTE_RELOGIO: decodifica = 5'b01000;
            AJUSTE_TIMER:   decodifica = 5'b10000;
            default:        decodifica = 5'b00001;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seletor_modo_debounce_botao.sv
`default_nettype none
// ============================================================================
// Module      : debounce_botao
// Description : Two-flop synchronizer, level debouncer and rising-edge press
//               pulse for a raw push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic press
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                // Level held long enough: accept it, pulse only on a rise
                r_level <= r_sync2;
                r_press <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/seletor_modo.sv
`default_nettype none
// ============================================================================
// Module      : seletor_modo
// Description : Display mode controller: debounced MODE button sequencing,
//               inactivity timeout, alarm override. Optional blink output
//               enabled with SELETOR_PISCA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seletor_modo
    import seletor_modo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_S       = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_modo,
    input  logic tick_1hz,
    input  logic atividade,
    input  logic alarme_timer,
    output logic modo_relogio,
    output logic modo_cronometro,
    output logic modo_timer,
    output logic modo_ajuste_relogio,
    output logic modo_ajuste_timer,
    output logic mudou_modo,
    output logic piscar
);

    localparam logic [c_TIMEOUT_W-1:0] c_TIMEOUT_LAST = c_TIMEOUT_W'(TIMEOUT_S - 1);

    logic                   w_press;
    modo_t                  r_state;
    modo_t                  w_state_next;
    logic [c_TIMEOUT_W-1:0] r_timeout_cnt;
    logic [c_TIMEOUT_W-1:0] w_timeout_cnt_next;
    logic                   w_timeout;
    logic                   w_entra_ajuste;
    logic [4:0]             r_modo;
    logic                   r_mudou;

    debounce_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (btn_modo),
        .press  (w_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RELOGIO;
            r_timeout_cnt <= '0;
            r_modo        <= decodifica(RELOGIO);
            r_mudou       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_timeout_cnt <= w_timeout_cnt_next;
            r_modo        <= decodifica(w_state_next);
            r_mudou       <= (w_state_next != r_state);
        end
    end

    // Priority: alarm > timeout > press; alarm ignored while editing the timer
    always_comb begin
        w_state_next       = r_state;
        w_timeout          = is_ajuste(r_state) && tick_1hz && !atividade &&
                             (r_timeout_cnt == c_TIMEOUT_LAST);
        w_entra_ajuste     = 1'b0;
        w_timeout_cnt_next = r_timeout_cnt;

        if (alarme_timer && (r_state != AJUSTE_TIMER)) begin
            w_state_next = TIMER;
        end else if (w_timeout) begin
            w_state_next = RELOGIO;
        end else if (w_press) begin
            w_state_next = proximo_modo(r_state);
        end

        w_entra_ajuste = is_ajuste(w_state_next) && (w_state_next != r_state);

        if (!is_ajuste(w_state_next) || w_entra_ajuste || atividade) begin
            w_timeout_cnt_next = '0;
        end else if (tick_1hz) begin
            w_timeout_cnt_next = r_timeout_cnt + c_TIMEOUT_W'(1);
        end
    end

    assign modo_relogio        = r_modo[0];
    assign modo_cronometro     = r_modo[1];
    assign modo_timer          = r_modo[2];
    assign modo_ajuste_relogio = r_modo[3];
    assign modo_ajuste_timer   = r_modo[4];
    assign mudou_modo          = r_mudou;

`ifdef SELETOR_PISCA_EN
    logic r_piscar;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_piscar <= 1'b0;
        end else if (!is_ajuste(w_state_next) || w_entra_ajuste) begin
            r_piscar <= 1'b0;
        end else if (tick_1hz) begin
            r_piscar <= ~r_piscar;
        end
    end

    assign piscar = r_piscar;
`else
    assign piscar = 1'b0;
`endif

endmodule
`default_nettype wire
